multicycle_controller: RTL and testbench

//  Main control FSM of the multicycle MIPS datapath. Decodes opcode from the instruction register and

---
 rtl/mips_pkg.sv | 66 ++++++
 rtl/multicycle_controller_if.sv | 33 +++
 rtl/ctrl_out_decode.sv | 95 +++++++++
 rtl/multicycle_controller.sv | 79 +++++++
 tb/tb_multicycle_controller.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, mux selects,
// ALU operation classes, controller states and the packed control word.
package mips_pkg;

    localparam int unsigned OPW    = 6;
    localparam int unsigned AOPW   = 2;
    localparam int unsigned SRCBW  = 2;
    localparam int unsigned PCSRCW = 2;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    localparam logic [AOPW-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [AOPW-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [AOPW-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SRCBW-1:0] SRCB_B      = 2'b00;
    localparam logic [SRCBW-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SRCBW-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SRCBW-1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [PCSRCW-1:0] PCSRC_ALURES = 2'b00;
    localparam logic [PCSRCW-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [PCSRCW-1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } ctrl_state_t;

    typedef struct packed {
        logic              mem_req;
        logic              memwrite;
        logic              irwrite;
        logic              iord;
        logic              alusrca;
        logic [SRCBW-1:0]  alusrcb;
        logic [AOPW-1:0]   aluop;
        logic [PCSRCW-1:0] pcsrc;
        logic              pc_en;
        logic              regwrite;
        logic              regdst;
        logic              memtoreg;
        logic              illegal;
    } ctrl_word_t;

    function automatic logic is_legal_op(input logic [OPW-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface multicycle_controller_if;

    logic [mips_pkg::OPW-1:0]    op;
    logic                        zero;
    logic                        mem_ready;
    logic                        mem_req;
    logic                        memwrite;
    logic                        irwrite;
    logic                        iord;
    logic                        alusrca;
    logic [mips_pkg::SRCBW-1:0]  alusrcb;
    logic [mips_pkg::AOPW-1:0]   aluop;
    logic [mips_pkg::PCSRCW-1:0] pcsrc;
    logic                        pc_en;
    logic                        regwrite;
    logic                        regdst;
    logic                        memtoreg;
    logic                        illegal;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, memwrite, irwrite, iord, alusrca, alusrcb, aluop,
               pcsrc, pc_en, regwrite, regdst, memtoreg, illegal
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, memwrite, irwrite, iord, alusrca, alusrcb, aluop,
               pcsrc, pc_en, regwrite, regdst, memtoreg, illegal
    );

endinterface

// File: rtl/ctrl_out_decode.sv
// Combinational state -> control word decode. While run is low the word takes
// FETCH mux settings with every enable forced off.
module ctrl_out_decode
    import mips_pkg::*;
(
    input  ctrl_state_t           state,
    input  logic                  run,
    input  logic [OPW-1:0]        op,
    input  logic                  zero,
    input  logic                  mem_ready,
    output ctrl_word_t            cw
);

    ctrl_state_t sel;
    logic        pcwrite;
    logic        branch;

    always_comb begin
        cw      = '0;
        pcwrite = 1'b0;
        branch  = 1'b0;
        sel     = run ? state : FETCH;

        case (sel)
            FETCH: begin
                cw.mem_req = 1'b1;
                cw.alusrcb = SRCB_FOUR;
                cw.aluop   = ALUOP_ADD;
                cw.pcsrc   = PCSRC_ALURES;
                cw.irwrite = mem_ready;
                pcwrite    = mem_ready;
            end
            DECODE: begin
                cw.alusrcb = SRCB_IMMSH2;
                cw.aluop   = ALUOP_ADD;
                cw.illegal = !is_legal_op(op);
            end
            MEMADR, ADDIEXEC: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_IMM;
                cw.aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                cw.mem_req = 1'b1;
                cw.iord    = 1'b1;
            end
            MEMWB: begin
                cw.regwrite = 1'b1;
                cw.memtoreg = 1'b1;
            end
            MEMWR: begin
                cw.mem_req  = 1'b1;
                cw.iord     = 1'b1;
                cw.memwrite = 1'b1;
            end
            EXECUTE: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_B;
                cw.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                cw.regwrite = 1'b1;
                cw.regdst   = 1'b1;
            end
            BRANCH: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_B;
                cw.aluop   = ALUOP_SUB;
                cw.pcsrc   = PCSRC_ALUOUT;
                branch     = 1'b1;
            end
            ADDIWB: begin
                cw.regwrite = 1'b1;
            end
            JUMP: begin
                cw.pcsrc = PCSRC_JUMP;
                pcwrite  = 1'b1;
            end
            default: ;
        endcase

        cw.pc_en = pcwrite | (branch & zero);

        // Reset cycle: keep FETCH mux settings but never let anything commit.
        if (!run) begin
            cw.mem_req  = 1'b0;
            cw.memwrite = 1'b0;
            cw.irwrite  = 1'b0;
            cw.pc_en    = 1'b0;
            cw.regwrite = 1'b0;
            cw.illegal  = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch through
// writeback and stalls memory states on mem_ready.
module multicycle_controller
    import mips_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    multicycle_controller_if.master bus
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    ctrl_word_t  cw;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEXEC;
                    OP_J:         state_next = JUMP;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_SW) begin
                    state_next = MEMWR;
                end else if (bus.op == OP_LW) begin
                    state_next = MEMRD;
                end else begin
                    state_next = FETCH;
                end
            end
            MEMRD:    state_next = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:    state_next = bus.mem_ready ? FETCH : MEMWR;
            EXECUTE:  state_next = ALUWB;
            ADDIEXEC: state_next = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    ctrl_out_decode u_decode (
        .state     (state),
        .run       (reset_n),
        .op        (bus.op),
        .zero      (bus.zero),
        .mem_ready (bus.mem_ready),
        .cw        (cw)
    );

    assign bus.mem_req  = cw.mem_req;
    assign bus.memwrite = cw.memwrite;
    assign bus.irwrite  = cw.irwrite;
    assign bus.iord     = cw.iord;
    assign bus.alusrca  = cw.alusrca;
    assign bus.alusrcb  = cw.alusrcb;
    assign bus.aluop    = cw.aluop;
    assign bus.pcsrc    = cw.pcsrc;
    assign bus.pc_en    = cw.pc_en;
    assign bus.regwrite = cw.regwrite;
    assign bus.regdst   = cw.regdst;
    assign bus.memtoreg = cw.memtoreg;
    assign bus.illegal  = cw.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: checks state sequence and the
// full control word every cycle against hand-written expectations.
module tb_multicycle_controller;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Word layout: mem_req memwrite irwrite iord alusrca alusrcb aluop pcsrc pc_en regwrite regdst memtoreg illegal
    function automatic logic [15:0] mk(input logic mr, input logic mw, input logic ir,
                                       input logic io, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] ao, input logic [1:0] ps,
                                       input logic pe, input logic rw, input logic rd,
                                       input logic mt, input logic il);
        return {mr, mw, ir, io, sa, sb, ao, ps, pe, rw, rd, mt, il};
    endfunction

    function automatic logic [15:0] obs();
        return {bus.mem_req, bus.memwrite, bus.irwrite, bus.iord, bus.alusrca, bus.alusrcb,
                bus.aluop, bus.pcsrc, bus.pc_en, bus.regwrite, bus.regdst, bus.memtoreg,
                bus.illegal};
    endfunction

    logic [15:0] w_fetch_rdy, w_fetch_wait, w_reset, w_decode, w_decode_ill, w_memadr,
                 w_memrd, w_memwb, w_memwr, w_exec, w_aluwb, w_br_t, w_br_nt, w_addiwb, w_jump;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs for the current cycle, check state and word, advance one clock.
    task automatic cyc(input string tag, input ctrl_state_t st, input logic [5:0] op,
                       input logic z, input logic rdy, input logic [15:0] w);
        bus.op        = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        #1;
        check({tag, "_state"}, 32'(dut.state), 32'(st));
        check({tag, "_word"}, 32'(obs()), 32'(w));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        w_fetch_rdy  = mk(1,0,1,0,0,2'b01,2'b00,2'b00,1,0,0,0,0);
        w_fetch_wait = mk(1,0,0,0,0,2'b01,2'b00,2'b00,0,0,0,0,0);
        w_reset      = mk(0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0,0,0);
        w_decode     = mk(0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0,0,0);
        w_decode_ill = mk(0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0,0,1);
        w_memadr     = mk(0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0,0,0);
        w_memrd      = mk(1,0,0,1,0,2'b00,2'b00,2'b00,0,0,0,0,0);
        w_memwb      = mk(0,0,0,0,0,2'b00,2'b00,2'b00,0,1,0,1,0);
        w_memwr      = mk(1,1,0,1,0,2'b00,2'b00,2'b00,0,0,0,0,0);
        w_exec       = mk(0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0,0,0);
        w_aluwb      = mk(0,0,0,0,0,2'b00,2'b00,2'b00,0,1,1,0,0);
        w_br_t       = mk(0,0,0,0,1,2'b00,2'b01,2'b01,1,0,0,0,0);
        w_br_nt      = mk(0,0,0,0,1,2'b00,2'b01,2'b01,0,0,0,0,0);
        w_addiwb     = mk(0,0,0,0,0,2'b00,2'b00,2'b00,0,1,0,0,0);
        w_jump       = mk(0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0,0,0);

        reset_n       = 1'b0;
        bus.op        = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(dut.state), 32'(FETCH));
        check("reset_word", 32'(obs()), 32'(w_reset));
        reset_n = 1'b1;

        // R-type add
        cyc("add_fetch", FETCH,   6'b000000, 0, 1, w_fetch_rdy);
        cyc("add_dec",   DECODE,  6'b000000, 0, 1, w_decode);
        cyc("add_exec",  EXECUTE, 6'b111111, 0, 1, w_exec);
        cyc("add_wb",    ALUWB,   6'b111111, 0, 1, w_aluwb);

        // lw with two wait cycles in FETCH and in MEMRD; op junk outside decode/memadr
        cyc("lw_fw0",   FETCH,  6'b111111, 0, 0, w_fetch_wait);
        cyc("lw_fw1",   FETCH,  6'b000100, 0, 0, w_fetch_wait);
        cyc("lw_fetch", FETCH,  6'b100011, 0, 1, w_fetch_rdy);
        cyc("lw_dec",   DECODE, 6'b100011, 0, 1, w_decode);
        cyc("lw_adr",   MEMADR, 6'b100011, 0, 1, w_memadr);
        cyc("lw_rd0",   MEMRD,  6'b101011, 0, 0, w_memrd);
        cyc("lw_rd1",   MEMRD,  6'b000010, 0, 0, w_memrd);
        cyc("lw_rd2",   MEMRD,  6'b000000, 0, 1, w_memrd);
        cyc("lw_wb",    MEMWB,  6'b000000, 0, 1, w_memwb);

        // beq taken then not taken
        cyc("beqt_fetch", FETCH,  6'b000100, 0, 1, w_fetch_rdy);
        cyc("beqt_dec",   DECODE, 6'b000100, 0, 1, w_decode);
        cyc("beqt_br",    BRANCH, 6'b000100, 1, 1, w_br_t);
        cyc("beqn_fetch", FETCH,  6'b000100, 0, 1, w_fetch_rdy);
        cyc("beqn_dec",   DECODE, 6'b000100, 0, 1, w_decode);
        cyc("beqn_br",    BRANCH, 6'b000100, 0, 1, w_br_nt);

        // sw with three wait cycles
        cyc("sw_fetch", FETCH,  6'b101011, 0, 1, w_fetch_rdy);
        cyc("sw_dec",   DECODE, 6'b101011, 0, 1, w_decode);
        cyc("sw_adr",   MEMADR, 6'b101011, 0, 1, w_memadr);
        cyc("sw_wr0",   MEMWR,  6'b100011, 0, 0, w_memwr);
        cyc("sw_wr1",   MEMWR,  6'b100011, 0, 0, w_memwr);
        cyc("sw_wr2",   MEMWR,  6'b100011, 0, 0, w_memwr);
        cyc("sw_wr3",   MEMWR,  6'b100011, 0, 1, w_memwr);

        // addi and j
        cyc("addi_fetch", FETCH,    6'b001000, 0, 1, w_fetch_rdy);
        cyc("addi_dec",   DECODE,   6'b001000, 0, 1, w_decode);
        cyc("addi_exec",  ADDIEXEC, 6'b001000, 0, 1, w_memadr);
        cyc("addi_wb",    ADDIWB,   6'b001000, 0, 1, w_addiwb);
        cyc("j_fetch",    FETCH,    6'b000010, 0, 1, w_fetch_rdy);
        cyc("j_dec",      DECODE,   6'b000010, 0, 1, w_decode);
        cyc("j_jump",     JUMP,     6'b000010, 0, 1, w_jump);

        // Unsupported opcode: single illegal pulse, back to FETCH
        cyc("ill_fetch", FETCH,  6'b111111, 0, 1, w_fetch_rdy);
        cyc("ill_dec",   DECODE, 6'b111111, 0, 1, w_decode_ill);
        cyc("ill_after", FETCH,  6'b111111, 0, 0, w_fetch_wait);

        // Reset asserted for two cycles in EXECUTE
        cyc("rst_fetch", FETCH,  6'b000000, 0, 1, w_fetch_rdy);
        cyc("rst_dec",   DECODE, 6'b000000, 0, 1, w_decode);
        reset_n = 1'b0;
        cyc("rst_exec",  EXECUTE, 6'b000000, 0, 1, w_reset);
        cyc("rst_hold",  FETCH,   6'b000000, 0, 1, w_reset);
        reset_n = 1'b1;
        cyc("rst_resume", FETCH,  6'b000000, 0, 1, w_fetch_rdy);
        cyc("rst_dec2",   DECODE, 6'b101011, 0, 1, w_decode);

        // Reset in the middle of a store wait
        cyc("swr_adr", MEMADR, 6'b101011, 0, 0, w_memadr);
        cyc("swr_wr",  MEMWR,  6'b101011, 0, 0, w_memwr);
        reset_n = 1'b0;
        cyc("swr_rst", MEMWR,  6'b101011, 0, 0, w_reset);
        reset_n = 1'b1;
        cyc("swr_restart", FETCH, 6'b101011, 0, 0, w_fetch_wait);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
